nn_mac_lanes: RTL and testbench

// Multiply-accumulate stage of the encrypted-NN datapath. Buffers one packed ciphertext word, then

---
 rtl/nn_mac_lanes_pkg.sv | 18 +
 rtl/nn_mac_lanes_if.sv | 32 +++
 rtl/nn_mac_lanes_lane_mul.sv | 13 +
 rtl/nn_mac_lanes.sv | 78 +++++++
 tb/tb_nn_mac_lanes.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_mac_lanes_pkg.sv
// nn_pkg: shared widths, lane types, FSM states and mod-2^COEF_W arithmetic helpers
package nn_pkg;
  localparam int COEF_W = 18;
  localparam int WEIGHT_W = 3;
  localparam int LANES = 2;
  typedef logic [COEF_W-1:0] coef_t;
  typedef coef_t [LANES-1:0] lanes_t;
  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef enum logic {IDLE, LOADED} state_t;
  function automatic coef_t mod_add(coef_t a, coef_t b);
    return a + b;
  endfunction
  function automatic coef_t smul(coef_t c, weight_t w);
    logic [COEF_W+WEIGHT_W-1:0] p;
    p = {{WEIGHT_W{c[COEF_W-1]}}, c} * {{COEF_W{w[WEIGHT_W-1]}}, w};
    return p[COEF_W-1:0];
  endfunction
endpackage

// File: rtl/nn_mac_lanes_if.sv
// nn_mac_lanes_if: ciphertext, weight, partial-sum and result handshakes of the MAC stage
interface nn_mac_lanes_if #(
  parameter int IDX_W = 10,
  parameter int WIDX_W = 6
);
  import nn_pkg::*;
  logic ct_valid, ct_ready;
  lanes_t ct_in;
  logic [IDX_W-1:0] idx_k_in, idx_N_in;
  logic weights_valid, weights_ready;
  weight_t weights_in;
  logic [WIDX_W-1:0] weight_idx;
  logic psum_valid, psum_ready;
  lanes_t psum_in;
  logic sum_ready, sum_valid;
  lanes_t sum_out;
  logic [IDX_W-1:0] sum_idx_k, sum_idx_N;
  logic [WIDX_W-1:0] sum_idx_w;
  logic err_order;
  modport master (
    output ct_valid, ct_in, idx_k_in, idx_N_in, weights_valid, weights_in, weight_idx,
           psum_valid, psum_in, sum_ready,
    input  ct_ready, weights_ready, psum_ready, sum_valid, sum_out, sum_idx_k, sum_idx_N,
           sum_idx_w, err_order
  );
  modport slave (
    input  ct_valid, ct_in, idx_k_in, idx_N_in, weights_valid, weights_in, weight_idx,
           psum_valid, psum_in, sum_ready,
    output ct_ready, weights_ready, psum_ready, sum_valid, sum_out, sum_idx_k, sum_idx_N,
           sum_idx_w, err_order
  );
endinterface

// File: rtl/nn_mac_lanes_lane_mul.sv
// nn_lane_mul: one lane's signed coefficient-by-weight product, optionally added to a partial sum
module nn_lane_mul
  import nn_pkg::*;
#(
  parameter bit ACC_MODE = 1'b1
) (
  input  coef_t   ct,
  input  coef_t   psum,
  input  weight_t w,
  output coef_t   sum
);
  assign sum = mod_add(ACC_MODE ? psum : '0, smul(ct, w));
endmodule

// File: rtl/nn_mac_lanes.sv
// nn_mac_lanes: buffers one packed ciphertext word and sweeps OUT_NODES weights against it
module nn_mac_lanes
  import nn_pkg::*;
#(
  parameter int OUT_NODES = 10,
  parameter int IDX_W = 10,
  parameter int WIDX_W = 6,
  parameter bit ACC_MODE = 1'b1
) (
  input logic clk_in,
  input logic rst_n_in,
  nn_mac_lanes_if.slave bus
);
  state_t state;
  lanes_t ct_buf, prod;
  logic [IDX_W-1:0] k_buf, n_buf;
  logic [WIDX_W-1:0] wcnt;
  logic slot_free, psum_ok, fire, take, last;
  assign slot_free = !bus.sum_valid || bus.sum_ready;
  assign psum_ok = ACC_MODE ? bus.psum_valid : 1'b1;
  assign bus.weights_ready = state == LOADED && slot_free && psum_ok;
  assign bus.psum_ready = ACC_MODE && state == LOADED && slot_free && bus.weights_valid;
  assign fire = bus.weights_ready && bus.weights_valid;
  assign take = state == IDLE && bus.ct_valid && bus.ct_ready;
  assign last = wcnt == WIDX_W'(OUT_NODES - 1);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    nn_lane_mul #(.ACC_MODE(ACC_MODE)) u_mul (
      .ct(ct_buf[i]),
      .psum(bus.psum_in[i]),
      .w(bus.weights_in),
      .sum(prod[i])
    );
  end
  // load/sweep sequencer with the ciphertext buffer and the registered result slot
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      wcnt <= '0;
      ct_buf <= '0;
      k_buf <= '0;
      n_buf <= '0;
      bus.ct_ready <= 1'b0;
      bus.sum_valid <= 1'b0;
      bus.sum_out <= '0;
      bus.sum_idx_k <= '0;
      bus.sum_idx_N <= '0;
      bus.sum_idx_w <= '0;
      bus.err_order <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bus.ct_ready <= !take;
        if (take) begin
          ct_buf <= bus.ct_in;
          k_buf <= bus.idx_k_in;
          n_buf <= bus.idx_N_in;
          wcnt <= '0;
          state <= LOADED;
        end
      end else if (fire && last) begin
        wcnt <= '0;
        state <= IDLE;
        bus.ct_ready <= 1'b1;
      end else if (fire) begin
        wcnt <= wcnt + 1'b1;
      end
      if (fire) begin
        bus.sum_valid <= 1'b1;
        bus.sum_out <= prod;
        bus.sum_idx_k <= k_buf;
        bus.sum_idx_N <= n_buf;
        bus.sum_idx_w <= bus.weight_idx;
        if (bus.weight_idx != wcnt) bus.err_order <= 1'b1;
      end else if (bus.sum_ready) begin
        bus.sum_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nn_mac_lanes.sv
// tb_nn_mac_lanes: scoreboard bench driving a plain-product and an accumulating instance side by side
module tb_nn_mac_lanes;
  import nn_pkg::*;
  localparam int N = 10;
  typedef struct packed {lanes_t s; logic [9:0] k; logic [9:0] n; logic [5:0] w;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ctv[2], wv[2], pvl[2], sr[2];
  lanes_t cti[2], psi[2], so[2], cur[2];
  logic [9:0] ikv[2], inv[2], sk[2], sn[2], ck[2], cn[2];
  weight_t wgt[2];
  logic [5:0] wi[2], sw[2];
  logic ctr[2], wrd[2], prd[2], sva[2], erro[2];
  int cnt[2];
  bit experr[2];
  exp_t q0[$], q1[$];
  int vec = 0, err = 0;
  always #5 clk = ~clk;
  nn_mac_lanes_if bus[2] ();
  for (genvar g = 0; g < 2; g++) begin : g_dut
    nn_mac_lanes #(.ACC_MODE(g == 1)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus[g]));
    assign bus[g].ct_valid = ctv[g];
    assign bus[g].ct_in = cti[g];
    assign bus[g].idx_k_in = ikv[g];
    assign bus[g].idx_N_in = inv[g];
    assign bus[g].weights_valid = wv[g];
    assign bus[g].weights_in = wgt[g];
    assign bus[g].weight_idx = wi[g];
    assign bus[g].psum_valid = pvl[g];
    assign bus[g].psum_in = psi[g];
    assign bus[g].sum_ready = sr[g];
    assign ctr[g] = bus[g].ct_ready;
    assign wrd[g] = bus[g].weights_ready;
    assign prd[g] = bus[g].psum_ready;
    assign sva[g] = bus[g].sum_valid;
    assign so[g] = bus[g].sum_out;
    assign sk[g] = bus[g].sum_idx_k;
    assign sn[g] = bus[g].sum_idx_N;
    assign sw[g] = bus[g].sum_idx_w;
    assign erro[g] = bus[g].err_order;
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h, required %h", nm, a, e);
    end
  endtask

  function automatic lanes_t rnd_lanes();
    return {coef_t'($urandom), coef_t'($urandom)};
  endfunction

  // result monitor: every presented result must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t a, e;
    int sz;
    if (rst_n) for (int m = 0; m < 2; m++) if (sva[m]) begin
      a = {so[m], sk[m], sn[m], sw[m]};
      sz = m == 0 ? q0.size() : q1.size();
      if (sz == 0) begin
        vec++;
        err++;
        $display("FAIL sum%0d: got unexpected result %h, required none", m, a);
      end else begin
        e = m == 0 ? q0[0] : q1[0];
        chk($sformatf("sum%0d", m), 64'(a), 64'(e));
        if (sr[m]) begin
          if (m == 0) q0.delete(0);
          else q1.delete(0);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      ctv[m] = 1'b0; cti[m] = '0; ikv[m] = '0; inv[m] = '0; wv[m] = 1'b0; wgt[m] = '0;
      wi[m] = '0; pvl[m] = 1'b0; psi[m] = '0; sr[m] = 1'b1; cnt[m] = 0; experr[m] = 1'b0;
    end
    q0.delete();
    q1.delete();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_flags%0d", m), 64'({sva[m], ctr[m], erro[m], wrd[m], prd[m]}), 64'(0));
      chk($sformatf("rst_sum%0d", m), 64'({so[m], sk[m], sn[m], sw[m]}), 64'(0));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) chk($sformatf("ct_ready_up%0d", m), 64'(ctr[m]), 64'(1));
  endtask

  task automatic load(input int m, input lanes_t c, input logic [9:0] k, input logic [9:0] n);
    ctv[m] = 1'b1; cti[m] = c; ikv[m] = k; inv[m] = n;
    @(negedge clk);
    for (int t = 0; !ctr[m]; t++) begin
      if (t == 200) begin
        $display("FAIL load%0d: ct_ready got 0, required 1 within 200 cycles", m);
        $fatal(1, "ct handshake timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ctv[m] = 1'b0; cur[m] = c; ck[m] = k; cn[m] = n; cnt[m] = 0;
    chk($sformatf("ct_busy%0d", m), 64'(ctr[m]), 64'(0));
  endtask

  task automatic wt(input int m, input weight_t w, input logic [5:0] idx, input lanes_t p, input int stall);
    exp_t e;
    wv[m] = 1'b1; wgt[m] = w; wi[m] = idx; psi[m] = p; pvl[m] = stall == 0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk($sformatf("stall_wr%0d", m), 64'(wrd[m]), 64'(0));
      chk($sformatf("stall_pr%0d", m), 64'(prd[m]), 64'(m == 1));
      @(posedge clk);
      #1;
    end
    pvl[m] = 1'b1;
    @(negedge clk);
    for (int t = 0; !wrd[m]; t++) begin
      if (t == 200) begin
        $display("FAIL wt%0d: weights_ready got 0, required 1 within 200 cycles", m);
        $fatal(1, "weight handshake timeout");
      end
      @(negedge clk);
    end
    for (int i = 0; i < LANES; i++)
      e.s[i] = coef_t'((m == 1 ? int'(p[i]) : 0) + int'(signed'(cur[m][i])) * int'(w));
    e.k = ck[m]; e.n = cn[m]; e.w = idx;
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
    if (int'(idx) != cnt[m]) experr[m] = 1'b1;
    cnt[m]++;
    @(posedge clk);
    #1;
    chk($sformatf("err_order%0d", m), 64'(erro[m]), 64'(experr[m]));
    if (cnt[m] == N) cnt[m] = 0;
    chk($sformatf("ct_ready%0d", m), 64'(ctr[m]), 64'(cnt[m] == 0));
  endtask

  task automatic idle(input int m);
    wv[m] = 1'b0;
    pvl[m] = 1'b0;
  endtask

  task automatic rsweep(input int m);
    bit done;
    done = 1'b0;
    load(m, rnd_lanes(), 10'($urandom), 10'($urandom));
    ctv[m] = 1'b1;
    cti[m] = rnd_lanes();
    fork
      begin
        for (int j = 0; j < N; j++) wt(m, weight_t'($urandom), 6'(j), rnd_lanes(), 0);
        ctv[m] = 1'b0;
        idle(m);
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1 sr[m] = $urandom_range(0, 2) != 0;
      end
    join
    sr[m] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 do_reset();
    for (int m = 0; m < 2; m++) begin
      wv[m] = 1'b1;
      pvl[m] = 1'b1;
    end
    repeat (2) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("idle_wr%0d", m), 64'(wrd[m]), 64'(0));
        chk($sformatf("idle_pr%0d", m), 64'(prd[m]), 64'(0));
      end
    end
    @(posedge clk);
    #1;
    idle(0);
    idle(1);
    load(0, {coef_t'(-3), coef_t'(5)}, 10'd3, 10'd7);
    for (int j = 0; j < N; j++) wt(0, weight_t'(1), 6'(j), '0, 0);
    idle(0);
    load(0, {coef_t'('h20000), coef_t'('h1FFFF)}, 10'd1, 10'd2);
    for (int j = 0; j < N; j++) wt(0, j % 2 == 0 ? weight_t'(-4) : weight_t'(3), 6'(j), '0, 0);
    idle(0);
    load(1, {coef_t'(2), coef_t'(1)}, 10'd5, 10'd9);
    wt(1, weight_t'(1), 6'd0, {coef_t'(7), coef_t'('h3FFFF)}, 3);
    for (int j = 1; j < N; j++) wt(1, weight_t'($urandom), 6'(j), rnd_lanes(), 0);
    idle(1);
    load(1, rnd_lanes(), 10'd11, 10'd12);
    fork
      begin
        for (int j = 0; j < N; j++) wt(1, weight_t'($urandom), 6'(j), rnd_lanes(), 0);
        idle(1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 sr[1] = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_wr1", 64'(wrd[1]), 64'(0));
        end
        @(posedge clk);
        #1 sr[1] = 1'b1;
      end
    join
    load(0, rnd_lanes(), 10'd20, 10'd21);
    wt(0, weight_t'(1), 6'd0, '0, 0);
    wt(0, weight_t'(1), 6'd1, '0, 0);
    wt(0, weight_t'(1), 6'd3, '0, 0);
    for (int j = 3; j < N; j++) wt(0, weight_t'($urandom), 6'(j), '0, 0);
    idle(0);
    load(1, rnd_lanes(), 10'd30, 10'd31);
    for (int j = 0; j < 5; j++) wt(1, weight_t'($urandom), 6'(j), rnd_lanes(), 0);
    do_reset();
    load(1, {coef_t'(4), coef_t'(6)}, 10'd40, 10'd41);
    for (int j = 0; j < N; j++) wt(1, weight_t'($urandom), 6'(j), rnd_lanes(), 0);
    idle(1);
    repeat (3) begin
      rsweep(0);
      rsweep(1);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("drain0", 64'(q0.size()), 64'(0));
    chk("drain1", 64'(q1.size()), 64'(0));
    for (int m = 0; m < 2; m++) chk($sformatf("final_valid%0d", m), 64'(sva[m]), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
